noc_traffic_gen: RTL
====================

Name: noc_traffic_gen

Overview:
- Synthesizable, parametrised flit traffic generator for one local port of the XY-routed mesh switch fabric.
- Builds head/body/tail packets with XY direction bits and injects them at a programmed rate into the switch input.
- Honours stop_out backpressure with a bounded slack window.
- Supersedes the behavioural per-port sender in mesh benches and in on-chip self-test: arbitrary mesh size, packet length, rate and destination mode.

Parameters:
- WORD_WIDTH, 32, flit width; must satisfy WORD_WIDTH-2 >= 4*COORD_W+5.
- MESH_X, 4, mesh columns.
- MESH_Y, 4, mesh rows.
- COORD_W, 3, bits per coordinate field.
- NODE_ID, 0, own node index. x = NODE_ID % MESH_X, y = NODE_ID / MESH_X.
- PKT_LEN, 3, flits per packet; minimum 2. Flits are head, PKT_LEN-2 bodies, then tail.
- NUM_PKTS, 200, packets to generate before finishing.
- RATE_CYCLES, 1000, injection period in clk cycles; minimum PKT_LEN.
- FIFO_DEPTH, 8, output flit FIFO depth (power of 2, >= PKT_LEN).
- SLACK, 2, flits that may still be sent after stop_out rises.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = generation allowed. Draining the FIFO is unaffected.
- dst_mode  in  1  0 = uniform random destination, 1 = fixed_dst.
- fixed_dst  in  clog2(MESH_X*MESH_Y)  destination node when dst_mode=1.
- stop_out  in  1  downstream stop request.
- DataIn  out  WORD_WIDTH  flit to switch input.
- DataVoidIn  out  1  1 = no flit this cycle.
- pkt_cnt  out  16  packets fully written into the FIFO.
- Finish  out  1  all packets generated and transmitted.

Behaviour:
- Reset values: DataIn=0, DataVoidIn=1, pkt_cnt=0, Finish=0. Also: FIFO empty, LFSR=SEED, slack=SLACK, period counter=0, FSM=IDLE.
- Flit type field [W-1:W-2]: 2'b10 head, 2'b00 body, 2'b01 tail.
- Head payload, from MSB downward starting at bit W-3: {srcY, srcX, dstY, dstX}, each COORD_W bits. Middle bits are zero. Bits [4:0] = {Loc, E, W, S, N}.
  - E = dstX>srcX; W = dstX<srcX.
  - N = dstY<srcY && dstX==srcX; S = dstY>srcY && dstX==srcX.
  - Loc = both coordinates equal.
- Body and tail payload [W-3:0] = current LFSR value, zero-extended or truncated.
- LFSR: 16-bit Galois, taps 0xB400. It advances every cycle the FSM writes a flit or samples a slot/destination.
- Destination (dst_mode=0): c = lfsr % (MESH_X*MESH_Y). If c==NODE_ID, use (c+1) % N. A packet never targets its own node in random mode.
- Destination (dst_mode=1): fixed_dst is used unmodified, including NODE_ID, which yields Loc=1.
- Period counter: runs 0..RATE_CYCLES-1, wrapping. At count 0, inject_slot = lfsr % RATE_CYCLES.
- FSM IDLE -> PEND: when count==inject_slot, enable=1 and pkt_cnt<NUM_PKTS.
- FSM PEND -> HEAD: when FIFO free entries >= PKT_LEN. This guarantees a packet is written contiguously, one flit per cycle.
- FSM HEAD -> BODY (repeated PKT_LEN-2 times) -> TAIL. HEAD latches the destination.
- FSM TAIL -> IDLE: pkt_cnt increments in the same cycle the tail is written.
- A slot reached while not in IDLE is skipped; there is no queueing of slots.
- Deasserting enable while in PEND or later does not abort the packet in progress.
- Send rule: a flit is popped when the FIFO is non-empty and slack>0.
  - DataIn/DataVoidIn are registered, so a flit appears 1 cycle after pop. Otherwise DataVoidIn=1 and DataIn=0.
- Slack counter:
  - Cycle with stop_out=1 and a pop: slack decrements.
  - Cycle with stop_out=0 and slack<SLACK: slack increments by 1.
  - Otherwise unchanged.
  - While stop_out stays high, exactly `slack` further flits are sent.
- Simultaneous FIFO write and pop in one cycle is legal, including when full-at-start with a pop.
- Finish rises the cycle after pkt_cnt==NUM_PKTS, FIFO empty and output register void. It is sticky until reset.
- Reset mid-packet: the partial packet is discarded (FIFO cleared). The next packet starts with a head flit.

Test Plan:
- Reset held 3 cycles -> DataVoidIn=1, DataIn=0, Finish=0, pkt_cnt=0 throughout and 1 cycle after release.
- NODE_ID=5, dst_mode=1, fixed_dst=14, PKT_LEN=3, stop_out=0 -> head 0x89680008. Then a body with [31:30]=00, then a tail with [31:30]=01, on consecutive cycles.
- NODE_ID=5, fixed_dst=13 -> head low bits 5'b00010 (S). fixed_dst=1 -> 5'b00001 (N). fixed_dst=5 -> 5'b10000 (Loc).
- dst_mode=0, 1000 packets, NODE_ID=0 -> no head has dstX=dstY=0. Every head's direction bits match its coordinates.
- FIFO holding 4 flits, stop_out raised and held, SLACK=2 -> exactly 2 more valid flits, then DataVoidIn=1. After stop_out drops, sending resumes within 2 cycles with no flit lost or duplicated.
- NUM_PKTS=2, PKT_LEN=4, RATE_CYCLES=8 -> exactly 8 flits (H,B,B,T ×2). Finish=1 one cycle after the last flit, pkt_cnt=2 remains. Reset asserted mid-second-packet -> next output begins with a head.

Source files
------------

// File: rtl/noc_traffic_gen.sv
// Flit traffic generator for one local port of an XY-routed mesh: builds head/body/tail
// packets at a programmed rate and drains them through a FIFO under stop_out backpressure.
module noc_traffic_gen #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned MESH_X      = 4,
    parameter int unsigned MESH_Y      = 4,
    parameter int unsigned COORD_W     = 3,
    parameter int unsigned NODE_ID     = 0,
    parameter int unsigned PKT_LEN     = 3,
    parameter int unsigned NUM_PKTS    = 200,
    parameter int unsigned RATE_CYCLES = 1000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SLACK       = 2,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                dst_mode,
    input  logic [$clog2(MESH_X*MESH_Y)-1:0]    fixed_dst,
    input  logic                                stop_out,
    output logic [WORD_WIDTH-1:0]               DataIn,
    output logic                                DataVoidIn,
    output logic [15:0]                         pkt_cnt,
    output logic                                Finish
);

    localparam int unsigned Nodes  = MESH_X * MESH_Y;
    localparam int unsigned NodeW  = $clog2(Nodes);
    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = (RATE_CYCLES > 1) ? $clog2(RATE_CYCLES) : 1;
    localparam int unsigned SlackW = $clog2(SLACK + 2);
    localparam int unsigned BodyW  = $clog2(PKT_LEN);
    localparam int unsigned PayW   = WORD_WIDTH - 2;
    localparam logic [COORD_W-1:0] SrcX = COORD_W'(NODE_ID % MESH_X);
    localparam logic [COORD_W-1:0] SrcY = COORD_W'(NODE_ID / MESH_X);

    typedef enum logic [2:0] {StIdle, StPend, StHead, StBody, StTail} state_e;

    state_e                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [CntW-1:0]       count_q, count_d, slot_q, slot_d, slot_now;
    logic [BodyW-1:0]      body_q, body_d;
    logic [15:0]           pkt_cnt_q, pkt_cnt_d;
    logic [SlackW-1:0]     slack_q, slack_d;
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]        fill_q, fill_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  void_q, void_d;
    logic                  finish_q, finish_d;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  wr_en, pop;
    logic [WORD_WIDTH-1:0] wr_data;
    logic [15:0]           rnd_c;
    logic [NodeW-1:0]      dst_node;
    logic [COORD_W-1:0]    dst_x, dst_y;
    logic [4:0]            dirs;
    logic [PayW-1:0]       head_pay, lfsr_pay;

    always_comb begin
        // Random mode never targets its own node: bump to the next index instead.
        rnd_c = lfsr_q % 16'(Nodes);
        if (rnd_c == 16'(NODE_ID)) begin
            rnd_c = (rnd_c + 16'd1) % 16'(Nodes);
        end
        dst_node = dst_mode ? fixed_dst : NodeW'(rnd_c);
        dst_x    = COORD_W'(32'(dst_node) % MESH_X);
        dst_y    = COORD_W'(32'(dst_node) / MESH_X);
        dirs[3]  = dst_x > SrcX;
        dirs[2]  = dst_x < SrcX;
        dirs[1]  = (dst_y > SrcY) && (dst_x == SrcX);
        dirs[0]  = (dst_y < SrcY) && (dst_x == SrcX);
        dirs[4]  = (dst_y == SrcY) && (dst_x == SrcX);
        head_pay = '0;
        head_pay[PayW-1 -: 4*COORD_W] = {SrcY, SrcX, dst_y, dst_x};
        head_pay[4:0] = dirs;
        lfsr_pay = PayW'(lfsr_q);
    end

    always_comb begin
        state_d   = state_q;
        body_d    = body_q;
        pkt_cnt_d = pkt_cnt_q;
        wr_en     = 1'b0;
        wr_data   = '0;
        // A fresh slot is drawn at count 0 and is immediately eligible.
        slot_now  = (count_q == '0) ? CntW'(32'(lfsr_q) % RATE_CYCLES) : slot_q;
        slot_d    = slot_now;
        count_d   = (count_q == CntW'(RATE_CYCLES - 1)) ? '0 : count_q + CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (count_q == slot_now && enable && pkt_cnt_q < 16'(NUM_PKTS)) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (fill_q <= (AddrW+1)'(FIFO_DEPTH - PKT_LEN)) begin
                    state_d = StHead;
                end
            end
            StHead: begin
                wr_en   = 1'b1;
                wr_data = {2'b10, head_pay};
                body_d  = '0;
                state_d = (PKT_LEN > 2) ? StBody : StTail;
            end
            StBody: begin
                wr_en   = 1'b1;
                wr_data = {2'b00, lfsr_pay};
                body_d  = body_q + BodyW'(1);
                if (32'(body_q) + 3 == PKT_LEN) begin
                    state_d = StTail;
                end
            end
            StTail: begin
                wr_en     = 1'b1;
                wr_data   = {2'b01, lfsr_pay};
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        lfsr_d = (wr_en || count_q == '0)
               ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    end

    always_comb begin
        pop     = (fill_q != '0) && (slack_q != '0);
        slack_d = slack_q;
        if (stop_out && pop) begin
            slack_d = slack_q - SlackW'(1);
        end else if (!stop_out && slack_q < SlackW'(SLACK)) begin
            slack_d = slack_q + SlackW'(1);
        end
        wr_ptr_d = wr_ptr_q + AddrW'(wr_en);
        rd_ptr_d = rd_ptr_q + AddrW'(pop);
        fill_d   = fill_q + (AddrW+1)'(wr_en) - (AddrW+1)'(pop);
        data_d   = pop ? mem_q[rd_ptr_q] : '0;
        void_d   = !pop;
        finish_d = finish_q || (pkt_cnt_q == 16'(NUM_PKTS) && fill_q == '0 && void_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            count_q   <= '0;
            slot_q    <= '0;
            body_q    <= '0;
            pkt_cnt_q <= '0;
            slack_q   <= SlackW'(SLACK);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            void_q    <= 1'b1;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            count_q   <= count_d;
            slot_q    <= slot_d;
            body_q    <= body_d;
            pkt_cnt_q <= pkt_cnt_d;
            slack_q   <= slack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            void_q    <= void_d;
            finish_q  <= finish_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign DataIn     = data_q;
    assign DataVoidIn = void_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign Finish     = finish_q;

endmodule
